pi_compensator: RTL and testbench

PI_COMPENSATOR -- requirements
Module: pi_compensator

---
 rtl/pi_compensator.sv | 167 ++++++++++++++++
 tb/tb_pi_compensator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_compensator.sv
// PI duty-cycle compensator for a DPWM; define PI_SOFTSTART_EN to add a per-update duty slew limit.
// Latency: 4 clocks from the accepting edge to duty_valid; one sample in flight, spacing >= 5 clocks.
// No backpressure: err_valid while busy is dropped and recorded in the sticky overrun flag.
module pi_compensator #(
    parameter logic [7:0] KP   = 8'd16,
    parameter logic [7:0] KI   = 8'd4,
    parameter logic [9:0] DMIN = 10'd4,
    parameter logic [9:0] SLEW = 10'd2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        EN,
    input  logic        err_valid,
    input  logic [12:0] err,
    input  logic [9:0]  maxcount,
    input  logic [9:0]  duty_init,
    output logic [9:0]  duty,
    output logic        duty_valid,
    output logic        busy,
    output logic        sat_hi,
    output logic        sat_lo,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROD  = 3'd1;
    localparam logic [2:0] S_INTEG = 3'd2;
    localparam logic [2:0] S_SUM   = 3'd3;
    localparam logic [2:0] S_CLAMP = 3'd4;

`ifdef PI_SOFTSTART_EN
    localparam bit SOFTSTART = 1'b1;
`else
    localparam bit SOFTSTART = 1'b0;
`endif

    localparam logic signed [20:0] KP_S = 21'(KP);
    localparam logic signed [20:0] KI_S = 21'(KI);

    logic [2:0]         state;
    logic signed [12:0] err_q;
    logic signed [20:0] p;
    logic signed [20:0] i_inc;
    logic signed [19:0] integ;
    logic signed [21:0] u;

    logic signed [21:0] integ_sum;
    logic signed [21:0] integ_cap;
    logic signed [21:0] integ_next;
    logic signed [13:0] raw;
    logic signed [14:0] raw_x;
    logic signed [14:0] lo_x;
    logic signed [14:0] hi_x;
    logic               narrow;
    logic [9:0]         bounded;
    logic               bound_hi;
    logic               bound_lo;
    logic [10:0]        up_lim;
    logic [9:0]         limited;
    logic [9:0]         duty_next;

    assign busy = (state != S_IDLE);

    // Integrator is held inside [0, maxcount<<8] so it can never wind up past the period.
    always_comb begin
        integ_sum  = 22'(integ) + 22'(i_inc);
        integ_cap  = $signed({4'd0, maxcount, 8'd0});
        integ_next = integ_sum;
        if (integ_sum < 22'sd0) begin
            integ_next = 22'sd0;
        end else if (integ_sum > integ_cap) begin
            integ_next = integ_cap;
        end
    end

    always_comb begin
        raw      = 14'(u >>> 8);
        raw_x    = 15'(raw);
        lo_x     = $signed({5'd0, DMIN});
        hi_x     = $signed({5'd0, maxcount - DMIN});
        narrow   = ({1'b0, maxcount} < {DMIN, 1'b0});
        bounded  = raw_x[9:0];
        bound_hi = 1'b0;
        bound_lo = 1'b0;
        if (narrow) begin
            // Period too short for both margins: park at mid-period and flag both ends.
            bounded  = maxcount >> 1;
            bound_hi = 1'b1;
            bound_lo = 1'b1;
        end else if (raw_x < lo_x) begin
            bounded  = DMIN;
            bound_lo = 1'b1;
        end else if (raw_x > hi_x) begin
            bounded  = maxcount - DMIN;
            bound_hi = 1'b1;
        end
    end

    // Slew step is taken relative to the duty currently driving the DPWM.
    always_comb begin
        up_lim  = {1'b0, duty} + {1'b0, SLEW};
        limited = bounded;
        if ({1'b0, bounded} > up_lim) begin
            limited = duty + SLEW;
        end else if (({1'b0, bounded} + {1'b0, SLEW}) < {1'b0, duty}) begin
            limited = duty - SLEW;
        end
        duty_next = SOFTSTART ? limited : bounded;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            err_q      <= '0;
            p          <= '0;
            i_inc      <= '0;
            integ      <= '0;
            u          <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (err_valid && busy) begin
                overrun <= 1'b1;
            end
            if (!EN) begin
                state <= S_IDLE;
                integ <= $signed({2'b00, duty_init, 8'd0});
                duty  <= duty_init;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (err_valid) begin
                            err_q <= $signed(err);
                            state <= S_PROD;
                        end
                    end
                    S_PROD: begin
                        p     <= KP_S * 21'(err_q);
                        i_inc <= KI_S * 21'(err_q);
                        state <= S_INTEG;
                    end
                    S_INTEG: begin
                        integ <= 20'(integ_next);
                        state <= S_SUM;
                    end
                    S_SUM: begin
                        u     <= 22'(integ) + 22'(p);
                        state <= S_CLAMP;
                    end
                    S_CLAMP: begin
                        duty       <= duty_next;
                        sat_hi     <= bound_hi;
                        sat_lo     <= bound_lo;
                        duty_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pi_compensator.sv
// Directed bench for pi_compensator: transaction-level model compared every cycle plus literal expectations.
module tb_pi_compensator;

    localparam int KP   = 16;
    localparam int KI   = 4;
    localparam int DMIN = 4;
    localparam int SLEW = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        EN;
    logic        err_valid;
    logic [12:0] err;
    logic [9:0]  maxcount;
    logic [9:0]  duty_init;
    logic [9:0]  duty;
    logic        duty_valid;
    logic        busy;
    logic        sat_hi;
    logic        sat_lo;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    bit cmp_on = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    pi_compensator dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .EN         (EN),
        .err_valid  (err_valid),
        .err        (err),
        .maxcount   (maxcount),
        .duty_init  (duty_init),
        .duty       (duty),
        .duty_valid (duty_valid),
        .busy       (busy),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo),
        .overrun    (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole sample computed at acceptance, revealed 4 edges later.
    int m_integ = 0, m_duty = 0, m_hi = 0, m_lo = 0, m_ovr = 0, m_valid = 0, m_cnt = 0;
    int r_duty = 0, r_hi = 0, r_lo = 0;

    task automatic model_accept(input int e, input int mc);
        int ig, uu, rw;
        ig = m_integ + KI * e;
        if (ig < 0) ig = 0;
        if (ig > mc * 256) ig = mc * 256;
        m_integ = ig;
        uu = ig + KP * e;
        rw = uu >>> 8;
        r_hi = 0;
        r_lo = 0;
        if (mc < 2 * DMIN) begin
            r_duty = mc / 2; r_hi = 1; r_lo = 1;
        end else if (rw < DMIN) begin
            r_duty = DMIN; r_lo = 1;
        end else if (rw > mc - DMIN) begin
            r_duty = mc - DMIN; r_hi = 1;
        end else begin
            r_duty = rw;
        end
    endtask

    task automatic model_finish();
        int d;
        d = r_duty;
`ifdef PI_SOFTSTART_EN
        if (d > m_duty + SLEW) d = m_duty + SLEW;
        else if (d < m_duty - SLEW) d = m_duty - SLEW;
`endif
        m_duty = d;
        m_hi = r_hi;
        m_lo = r_lo;
        m_valid = 1;
    endtask

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_integ = 0; m_duty = 0; m_hi = 0; m_lo = 0; m_ovr = 0; m_valid = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            if (err_valid && m_cnt > 0) m_ovr = 1;
            if (!EN) begin
                m_cnt = 0;
                m_integ = int'(duty_init) * 256;
                m_duty = int'(duty_init);
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) model_finish();
            end else if (err_valid) begin
                int e;
                e = $signed(err);
                model_accept(e, int'(maxcount));
                m_cnt = 4;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (cmp_on) begin
            check("duty", int'(duty), m_duty);
            check("duty_valid", int'(duty_valid), m_valid);
            check("busy", int'(busy), int'(m_cnt > 0));
            check("sat_hi", int'(sat_hi), m_hi);
            check("sat_lo", int'(sat_lo), m_lo);
            check("overrun", int'(overrun), m_ovr);
        end
        if (duty_valid) nvalid++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input int e);
        err = 13'(e);
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int lat;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (duty_valid) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, lat, 4);
    endtask

    task automatic reload();
        EN = 1'b0;
        tick();
        EN = 1'b1;
        tick();
    endtask

    initial begin
        int n0;
        reset = 1'b0; EN = 1'b0; err_valid = 1'b0; err = '0;
        maxcount = 10'd322; duty_init = 10'd150;
        #1 reset = 1'b1;
        #2 cmp_on = 1'b1;
        tick(); tick();
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        tick(); tick();
        check("preload_duty", int'(duty), 150);

        // Nominal small positive error
        EN = 1'b1;
        tick();
        send(64);
        wait_valid("nominal");
`ifdef PI_SOFTSTART_EN
        check("nominal_duty", int'(duty), 152);
`else
        check("nominal_duty", int'(duty), 155);
`endif
        check("nominal_sat", int'({sat_hi, sat_lo}), 0);
        tick();
        check("nominal_pulse", int'(duty_valid), 0);

        // Full negative error hits the lower margin
        reload();
        send(-4096);
        wait_valid("neg");
`ifdef PI_SOFTSTART_EN
        check("neg_duty", int'(duty), 148);
`else
        check("neg_duty", int'(duty), 4);
`endif
        check("neg_sat_lo", int'(sat_lo), 1);
        check("neg_sat_hi", int'(sat_hi), 0);

        // Repeated full positive error saturates the integrator
        reload();
        for (int k = 0; k < 6; k++) begin
            send(4095);
            wait_valid("pos");
`ifndef PI_SOFTSTART_EN
            check("pos_duty", int'(duty), 318);
`endif
            check("pos_sat_hi", int'(sat_hi), 1);
        end
        check("model_integ_sat", m_integ, 82432);
        send(-2048);
        wait_valid("unwind");
        check("unwind_duty", int'(duty), 162);
        check("unwind_sat", int'({sat_hi, sat_lo}), 0);

        // Mid-range negative correction
        duty_init = 10'd200;
        reload();
        send(-300);
        wait_valid("mid");
`ifdef PI_SOFTSTART_EN
        check("mid_duty", int'(duty), 198);
`else
        check("mid_duty", int'(duty), 176);
`endif

        // Overrun: second strobe two clocks after acceptance is dropped
        duty_init = 10'd150;
        reload();
        n0 = nvalid;
        send(64);
        tick();
        err = 13'd999;
        err_valid = 1'b1;
        tick();
        err_valid = 1'b0;
        repeat (8) tick();
        check("ovr_valid_count", nvalid - n0, 1);
`ifdef PI_SOFTSTART_EN
        check("ovr_duty", int'(duty), 152);
`else
        check("ovr_duty", int'(duty), 155);
`endif
        check("ovr_flag", int'(overrun), 1);
        reload();
        check("ovr_sticky", int'(overrun), 1);

        // Asynchronous reset while the sample sits in SUM
        send(64);
        tick(); tick();
        n0 = nvalid;
        #2 reset = 1'b1;
        #1;
        check("areset_duty", int'(duty), 0);
        check("areset_valid", int'(duty_valid), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_flags", int'({sat_hi, sat_lo, overrun}), 0);
        repeat (3) tick();
        reset = 1'b0;
        EN = 1'b0;
        tick();
        check("post_reset_duty", int'(duty), 150);
        repeat (4) tick();
        check("areset_no_valid", nvalid - n0, 0);

        // EN dropped mid-sample aborts without a result
        EN = 1'b1;
        tick();
        n0 = nvalid;
        send(64);
        tick();
        EN = 1'b0;
        repeat (6) tick();
        check("abort_no_valid", nvalid - n0, 0);
        check("abort_duty", int'(duty), 150);
        check("abort_busy", int'(busy), 0);

        // Period shorter than both margins
        maxcount = 10'd7;
        duty_init = 10'd2;
        reload();
        send(100);
        wait_valid("narrow");
        check("narrow_duty", int'(duty), 3);
        check("narrow_sat", int'({sat_hi, sat_lo}), 3);

        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
